// File: rtl/uart_tx_slow_peer.sv
// uart_tx_slow_peer: UART transmitter with a one-word holding register and valid/ready input.
// Ports:
//   clk     - system clock
//   rst     - synchronous active-high reset
//   i_vld   - upstream word valid
//   i_data  - word to transmit, sampled only on the accepting edge
//   o_rdy   - holding register empty (registered); accept on i_vld && o_rdy
//   tx      - registered serial line, idle high
//   o_busy  - a frame is on the line or a word is held
module uart_tx_slow_peer #(
    parameter int    DATA_WIDTH   = 8,
    parameter string PARITY_CHECK = "NONE",
    parameter int    CLK_FREQ     = 50000000,
    parameter int    BAUD_RATE    = 9600,
    parameter int    STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_vld,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_rdy,
    output logic                  tx,
    output logic                  o_busy
);
    localparam int BIT_CYCLES = CLK_FREQ / BAUD_RATE;
    localparam int CW = $clog2(BIT_CYCLES);
    localparam int IW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] RELOAD = CW'(BIT_CYCLES - 1);
    localparam bit PAR_EN  = PARITY_CHECK != "NONE";
    localparam bit PAR_ODD = PARITY_CHECK == "ODD";

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    if (DATA_WIDTH < 2) begin : g_chk_dw
        $fatal(1, "DATA_WIDTH must be at least 2");
    end
    if (DATA_WIDTH > 8) begin : g_warn_dw
        $warning("DATA_WIDTH above 8 is unusual for UART");
    end
    if (PARITY_CHECK != "NONE" && PARITY_CHECK != "EVEN" && PARITY_CHECK != "ODD") begin : g_chk_par
        $fatal(1, "PARITY_CHECK must be NONE, EVEN or ODD");
    end
    if (BIT_CYCLES < 16) begin : g_chk_baud
        $fatal(1, "CLK_FREQ/BAUD_RATE must be at least 16");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_chk_stop
        $fatal(1, "STOP_BITS must be 1 or 2");
    end

    logic [2:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
    logic                  hold_full_q, hold_full_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_q, par_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  stop_q, stop_d;
    logic                  tx_q, tx_d;
    logic                  rdy_q, rdy_d;
    logic                  accept, tick, load, last_bit, last_stop;

    assign last_bit  = idx_q == IW'(DATA_WIDTH - 1);
    assign last_stop = stop_q == 1'(STOP_BITS - 1);

    always_comb begin
        accept      = i_vld && rdy_q;
        tick        = cnt_q == '0;
        load        = 1'b0;
        state_d     = state_q;
        hold_data_d = hold_data_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        par_d       = par_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        stop_d      = stop_q;
        tx_d        = tx_q;
        if (state_q == S_IDLE) begin
            load = hold_full_q;
        end else begin
            cnt_d = tick ? RELOAD : cnt_q - 1'b1;
            if (tick) begin
                if (state_q == S_START || (state_q == S_DATA && !last_bit)) begin
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    idx_d   = (state_q == S_DATA) ? idx_q + 1'b1 : idx_q;
                end else if (state_q == S_DATA) begin
                    state_d = PAR_EN ? S_PARITY : S_STOP;
                    tx_d    = PAR_EN ? par_q : 1'b1;
                    stop_d  = 1'b0;
                end else if (state_q == S_PARITY) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                    stop_d  = 1'b0;
                end else if (last_stop) begin
                    // a held word starts on this same edge: no idle gap between frames
                    state_d = S_IDLE;
                    load    = hold_full_q;
                end else begin
                    stop_d = 1'b1;
                end
            end
        end
        if (load) begin
            state_d     = S_START;
            shift_d     = hold_data_q;
            par_d       = PAR_ODD ? ~^hold_data_q : ^hold_data_q;
            hold_full_d = 1'b0;
            cnt_d       = RELOAD;
            idx_d       = '0;
            stop_d      = 1'b0;
            tx_d        = 1'b0;
        end
        // accept and load never coincide: rdy_q is low whenever hold_full_q is set
        if (accept) begin
            hold_data_d = i_data;
            hold_full_d = 1'b1;
        end
        // stays low for the accepting edge and the following load edge
        rdy_d = !rst && !hold_full_q && !accept;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            hold_data_q <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            cnt_q       <= '0;
            idx_q       <= '0;
            stop_q      <= 1'b0;
            tx_q        <= 1'b1;
            rdy_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_data_q <= hold_data_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            stop_q      <= stop_d;
            tx_q        <= tx_d;
            rdy_q       <= rdy_d;
        end
    end

    assign o_rdy  = rdy_q;
    assign tx     = tx_q;
    assign o_busy = (state_q != S_IDLE) || hold_full_q;
endmodule
